// File: rtl/alu_cmd_loader_pkg.sv
// alu_cmd_loader shared definitions: ALU opcodes, fault codes, framer
// state encoding and an opcode validity helper.
package alu_cmd_loader_pkg;

    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_MUL = 8'h03;
    localparam logic [7:0] OP_DIV = 8'h04;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_BAD_OP   = 3'd1,
        ERR_TIMEOUT  = 3'd2,
        ERR_OVERRUN  = 3'd3,
        ERR_DIV_ZERO = 3'd4
    } err_code_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NUM1,
        S_NUM2,
        S_DISPATCH,
        S_WAIT_ALU
    } state_e;

    function automatic logic is_valid_op(input logic [7:0] b);
        return (b == OP_ADD) || (b == OP_SUB) ||
               (b == OP_MUL) || (b == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_cmd_loader_if.sv
// Byte-in / command-out bundle between UART rx, framer and ALU.
// slave: framer side; master: UART rx + ALU side (drives rx bytes, done).
interface alu_cmd_loader_if #(
    parameter int BITNESS = 8
);
    logic [7:0]         i_rx_data;
    logic               i_rx_valid;
    logic               i_alu_done;
    logic [7:0]         o_op_code;
    logic [BITNESS-1:0] o_num_1;
    logic [BITNESS-1:0] o_num_2;
    logic               o_alu_ready;
    logic               o_busy;
    logic               o_error;
    logic [2:0]         o_err_code;

    modport slave (
        input  i_rx_data, i_rx_valid, i_alu_done,
        output o_op_code, o_num_1, o_num_2,
        output o_alu_ready, o_busy, o_error, o_err_code
    );

    modport master (
        output i_rx_data, i_rx_valid, i_alu_done,
        input  o_op_code, o_num_1, o_num_2,
        input  o_alu_ready, o_busy, o_error, o_err_code
    );
endinterface

// File: rtl/alu_cmd_timeout.sv
// Loadable down-counter: load -> TIMEOUT_CYCLES, counts while en.
// Ports: i_clk, reset (sync, high), load, en; expired = en on last count.
module alu_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic i_clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(TIMEOUT_CYCLES);
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // After a load, the TIMEOUT_CYCLES-th enabled cycle sees cnt == 1.
    assign expired = en && (cnt == W'(1));
endmodule

// File: rtl/alu_cmd_loader.sv
// Frames opcode + two BITNESS-wide operands from rx bytes, dispatches to ALU.
// Ports: i_clk, reset (sync, high), bus (alu_cmd_loader_if.slave).
// Option: ALU_DIV_ZERO_CHECK_EN rejects DIV frames with num_2 == 0.
module alu_cmd_loader
    import alu_cmd_loader_pkg::*;
#(
    parameter int BITNESS        = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic              i_clk,
    input  logic              reset,
    alu_cmd_loader_if.slave   bus
);
    localparam int BYTES = BITNESS / 8;
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    state_e             state;
    logic [CW-1:0]      byte_cnt;
    logic [7:0]         op_reg;
    logic [BITNESS-1:0] n1;
    logic [BITNESS-1:0] n2;
    logic [BITNESS-1:0] n1_nxt;
    logic [BITNESS-1:0] n2_nxt;
    logic               last_byte;
    logic               in_frame;
    logic               tmo_load;
    logic               tmo_en;
    logic               tmo_exp;
    logic               div_zero;

    // Shift left one byte, new byte into the LSBs (MSB-first framing).
    assign n1_nxt    = BITNESS'({n1, bus.i_rx_data});
    assign n2_nxt    = BITNESS'({n2, bus.i_rx_data});
    assign last_byte = (byte_cnt == CW'(BYTES - 1));
    assign in_frame  = (state == S_NUM1) || (state == S_NUM2);

    // Reload on every byte in a frame, and while idle/dispatching so
    // each timed state starts with a full window.
    assign tmo_load = (state == S_IDLE) || (state == S_DISPATCH) ||
                      (in_frame && bus.i_rx_valid);
    assign tmo_en   = in_frame || (state == S_WAIT_ALU);

`ifdef ALU_DIV_ZERO_CHECK_EN
    assign div_zero = (op_reg == OP_DIV) && (n2_nxt == '0);
`else
    assign div_zero = 1'b0;
`endif

    alu_cmd_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk   (i_clk),
        .reset   (reset),
        .load    (tmo_load),
        .en      (tmo_en),
        .expired (tmo_exp)
    );

    assign bus.o_busy = (state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (reset) begin
            state           <= S_IDLE;
            byte_cnt        <= '0;
            op_reg          <= '0;
            n1              <= '0;
            n2              <= '0;
            bus.o_op_code   <= '0;
            bus.o_num_1     <= '0;
            bus.o_num_2     <= '0;
            bus.o_alu_ready <= 1'b0;
            bus.o_error     <= 1'b0;
            bus.o_err_code  <= '0;
        end else begin
            bus.o_alu_ready <= 1'b0;
            bus.o_error     <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.i_rx_valid) begin
                        if (is_valid_op(bus.i_rx_data)) begin
                            op_reg   <= bus.i_rx_data;
                            byte_cnt <= '0;
                            state    <= S_NUM1;
                        end else begin
                            bus.o_error    <= 1'b1;
                            bus.o_err_code <= ERR_BAD_OP;
                        end
                    end
                end
                S_NUM1: begin
                    if (bus.i_rx_valid) begin
                        n1 <= n1_nxt;
                        if (last_byte) begin
                            byte_cnt <= '0;
                            state    <= S_NUM2;
                        end else begin
                            byte_cnt <= byte_cnt + CW'(1);
                        end
                    end else if (tmo_exp) begin
                        state          <= S_IDLE;
                        bus.o_error    <= 1'b1;
                        bus.o_err_code <= ERR_TIMEOUT;
                    end
                end
                S_NUM2: begin
                    if (bus.i_rx_valid) begin
                        n2 <= n2_nxt;
                        if (last_byte) begin
                            byte_cnt <= '0;
                            if (div_zero) begin
                                state          <= S_IDLE;
                                bus.o_error    <= 1'b1;
                                bus.o_err_code <= ERR_DIV_ZERO;
                            end else begin
                                bus.o_op_code   <= op_reg;
                                bus.o_num_1     <= n1;
                                bus.o_num_2     <= n2_nxt;
                                bus.o_alu_ready <= 1'b1;
                                state           <= S_DISPATCH;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + CW'(1);
                        end
                    end else if (tmo_exp) begin
                        state          <= S_IDLE;
                        bus.o_error    <= 1'b1;
                        bus.o_err_code <= ERR_TIMEOUT;
                    end
                end
                S_DISPATCH: begin
                    state <= S_WAIT_ALU;
                    if (bus.i_rx_valid) begin
                        bus.o_error    <= 1'b1;
                        bus.o_err_code <= ERR_OVERRUN;
                    end
                end
                S_WAIT_ALU: begin
                    if (bus.i_rx_valid) begin
                        bus.o_error    <= 1'b1;
                        bus.o_err_code <= ERR_OVERRUN;
                    end
                    // A timeout outranks a simultaneous overrun byte.
                    if (bus.i_alu_done) begin
                        state <= S_IDLE;
                    end else if (tmo_exp) begin
                        state          <= S_IDLE;
                        bus.o_error    <= 1'b1;
                        bus.o_err_code <= ERR_TIMEOUT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_loader.sv
// Bench for alu_cmd_loader: frame-level reference model checked every
// cycle, directed literal checks, then randomized byte/done/reset traffic.
module tb_alu_cmd_loader;
    localparam int BW    = 16;
    localparam int T     = 12;
    localparam int BYTES = BW / 8;
    localparam int FLEN  = 1 + 2 * BYTES;

    logic i_clk = 1'b0;
    logic reset = 1'b1;

    alu_cmd_loader_if #(.BITNESS(BW)) bus ();

    alu_cmd_loader #(
        .BITNESS        (BW),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .i_clk (i_clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a queue of collected frame bytes plus pending
    // dispatch / waiting-for-ALU flags, stepped once per rising edge.
    logic [7:0]    m_frame[$];
    bit            m_started = 0;
    bit            m_disp    = 0;
    bit            m_wait    = 0;
    int            m_idle    = 0;
    int            m_wcnt    = 0;
    logic [7:0]    e_op      = '0;
    logic [BW-1:0] e_n1      = '0;
    logic [BW-1:0] e_n2      = '0;
    logic          e_ready   = 1'b0;
    logic          e_busy    = 1'b0;
    logic          e_err     = 1'b0;
    logic [2:0]    e_code    = '0;

    initial begin
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        forever begin
            @(posedge i_clk);
            m_started = 1;
            e_ready   = 1'b0;
            e_err     = 1'b0;
            if (reset) begin
                m_frame.delete();
                m_disp = 0;
                m_wait = 0;
                e_op   = '0;
                e_n1   = '0;
                e_n2   = '0;
                e_code = '0;
            end else if (m_disp) begin
                if (bus.i_rx_valid) begin
                    e_err  = 1'b1;
                    e_code = 3'd3;
                end
                m_disp = 0;
                m_wait = 1;
                m_wcnt = 0;
            end else if (m_wait) begin
                m_wcnt++;
                if (bus.i_rx_valid) begin
                    e_err  = 1'b1;
                    e_code = 3'd3;
                end
                if (bus.i_alu_done) begin
                    m_wait = 0;
                end else if (m_wcnt == T) begin
                    m_wait = 0;
                    e_err  = 1'b1;
                    e_code = 3'd2;
                end
            end else if (m_frame.size() == 0) begin
                if (bus.i_rx_valid) begin
                    if (bus.i_rx_data >= 8'd1 && bus.i_rx_data <= 8'd4) begin
                        m_frame.push_back(bus.i_rx_data);
                        m_idle = 0;
                    end else begin
                        e_err  = 1'b1;
                        e_code = 3'd1;
                    end
                end
            end else begin
                if (bus.i_rx_valid) begin
                    m_frame.push_back(bus.i_rx_data);
                    m_idle = 0;
                    if (m_frame.size() == FLEN) begin
                        a = '0;
                        b = '0;
                        for (int i = 0; i < BYTES; i++) begin
                            a = a * 256 + BW'(m_frame[1 + i]);
                            b = b * 256 + BW'(m_frame[1 + BYTES + i]);
                        end
`ifdef ALU_DIV_ZERO_CHECK_EN
                        if (m_frame[0] == 8'd4 && b == 0) begin
                            e_err  = 1'b1;
                            e_code = 3'd4;
                        end else begin
                            e_op    = m_frame[0];
                            e_n1    = a;
                            e_n2    = b;
                            e_ready = 1'b1;
                            m_disp  = 1;
                        end
`else
                        e_op    = m_frame[0];
                        e_n1    = a;
                        e_n2    = b;
                        e_ready = 1'b1;
                        m_disp  = 1;
`endif
                        m_frame.delete();
                    end
                end else begin
                    m_idle++;
                    if (m_idle == T) begin
                        m_frame.delete();
                        e_err  = 1'b1;
                        e_code = 3'd2;
                    end
                end
            end
            e_busy = (m_frame.size() > 0) || m_disp || m_wait;
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge i_clk);
            if (m_started) begin
                chk("m_op",    32'(bus.o_op_code),   32'(e_op));
                chk("m_num1",  32'(bus.o_num_1),     32'(e_n1));
                chk("m_num2",  32'(bus.o_num_2),     32'(e_n2));
                chk("m_ready", 32'(bus.o_alu_ready), 32'(e_ready));
                chk("m_busy",  32'(bus.o_busy),      32'(e_busy));
                chk("m_err",   32'(bus.o_error),     32'(e_err));
                chk("m_code",  32'(bus.o_err_code),  32'(e_code));
            end
        end
    end

    task automatic send_byte(input logic [7:0] d);
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = d;
        @(negedge i_clk);
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic pulse_done();
        bus.i_alu_done = 1'b1;
        @(negedge i_clk);
        bus.i_alu_done = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [15:0] x,
                              input logic [15:0] y);
        send_byte(op);
        send_byte(x[15:8]);
        send_byte(x[7:0]);
        send_byte(y[15:8]);
        send_byte(y[7:0]);
    endtask

    initial begin
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
        bus.i_alu_done = 1'b0;
        reset = 1'b1;
        idle(3);
        chk("rst_op",    32'(bus.o_op_code),   32'h0);
        chk("rst_num1",  32'(bus.o_num_1),     32'h0);
        chk("rst_num2",  32'(bus.o_num_2),     32'h0);
        chk("rst_ready", 32'(bus.o_alu_ready), 32'h0);
        chk("rst_busy",  32'(bus.o_busy),      32'h0);
        chk("rst_err",   32'(bus.o_error),     32'h0);
        chk("rst_code",  32'(bus.o_err_code),  32'h0);
        reset = 1'b0;
        idle(1);

        send_frame(8'h03, 16'h1234, 16'h0002);
        chk("a_ready", 32'(bus.o_alu_ready), 32'h1);
        chk("a_op",    32'(bus.o_op_code),   32'h03);
        chk("a_num1",  32'(bus.o_num_1),     32'h1234);
        chk("a_num2",  32'(bus.o_num_2),     32'h0002);
        idle(1);
        chk("a_ready1", 32'(bus.o_alu_ready), 32'h0);
        chk("a_busy",   32'(bus.o_busy),      32'h1);
        pulse_done();
        chk("a_idle",   32'(bus.o_busy),      32'h0);

        send_byte(8'h07);
        chk("b_err",  32'(bus.o_error),    32'h1);
        chk("b_code", 32'(bus.o_err_code), 32'h1);
        chk("b_busy", 32'(bus.o_busy),     32'h0);
        send_frame(8'h01, 16'h0005, 16'h0003);
        chk("b_ready", 32'(bus.o_alu_ready), 32'h1);
        chk("b_num1",  32'(bus.o_num_1),     32'h0005);
        chk("b_num2",  32'(bus.o_num_2),     32'h0003);
        idle(1);
        pulse_done();

        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h09);
        idle(T - 1);
        chk("c_pre_err",  32'(bus.o_error), 32'h0);
        chk("c_pre_busy", 32'(bus.o_busy),  32'h1);
        idle(1);
        chk("c_err",  32'(bus.o_error),    32'h1);
        chk("c_code", 32'(bus.o_err_code), 32'h2);
        chk("c_busy", 32'(bus.o_busy),     32'h0);
        send_frame(8'h02, 16'h0009, 16'h0004);
        chk("c_ready", 32'(bus.o_alu_ready), 32'h1);
        chk("c_op",    32'(bus.o_op_code),   32'h02);
        chk("c_num1",  32'(bus.o_num_1),     32'h0009);
        chk("c_num2",  32'(bus.o_num_2),     32'h0004);

        idle(1);
        send_byte(8'hAA);
        chk("d_err",   32'(bus.o_error),     32'h1);
        chk("d_code",  32'(bus.o_err_code),  32'h3);
        chk("d_busy",  32'(bus.o_busy),      32'h1);
        chk("d_ready", 32'(bus.o_alu_ready), 32'h0);
        idle(3);
        chk("d_ready2", 32'(bus.o_alu_ready), 32'h0);
        chk("d_busy2",  32'(bus.o_busy),      32'h1);
        pulse_done();
        chk("d_idle", 32'(bus.o_busy), 32'h0);

        send_byte(8'h01);
        idle(T - 1);
        send_byte(8'h00);
        idle(T - 1);
        send_byte(8'h07);
        send_byte(8'h00);
        send_byte(8'h01);
        chk("e_ready", 32'(bus.o_alu_ready), 32'h1);
        chk("e_num1",  32'(bus.o_num_1),     32'h0007);
        chk("e_num2",  32'(bus.o_num_2),     32'h0001);
        idle(T);
        chk("f_busy", 32'(bus.o_busy),  32'h1);
        chk("f_err0", 32'(bus.o_error), 32'h0);
        idle(1);
        chk("f_err",  32'(bus.o_error),    32'h1);
        chk("f_code", 32'(bus.o_err_code), 32'h2);
        chk("f_idle", 32'(bus.o_busy),     32'h0);

        send_frame(8'h04, 16'h0008, 16'h0000);
`ifdef ALU_DIV_ZERO_CHECK_EN
        chk("g_ready", 32'(bus.o_alu_ready), 32'h0);
        chk("g_err",   32'(bus.o_error),     32'h1);
        chk("g_code",  32'(bus.o_err_code),  32'h4);
        chk("g_busy",  32'(bus.o_busy),      32'h0);
        chk("g_num2",  32'(bus.o_num_2),     32'h0001);
`else
        chk("g_ready", 32'(bus.o_alu_ready), 32'h1);
        chk("g_op",    32'(bus.o_op_code),   32'h04);
        chk("g_num2",  32'(bus.o_num_2),     32'h0000);
        idle(1);
        pulse_done();
`endif

        send_byte(8'h01);
        send_byte(8'h00);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("h_busy", 32'(bus.o_busy),    32'h0);
        chk("h_op",   32'(bus.o_op_code), 32'h0);

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 2) begin
                bus.i_rx_valid = 1'b0;
                bus.i_alu_done = 1'b0;
                idle($urandom_range(T - 2, T + 3));
            end else begin
                reset          = ($urandom_range(0, 299) == 0);
                bus.i_rx_valid = ($urandom_range(0, 99) < 55);
                bus.i_alu_done = ($urandom_range(0, 99) < 15);
                if (m_frame.size() == 0 && !m_disp && !m_wait &&
                    $urandom_range(0, 99) < 80)
                    bus.i_rx_data = 8'($urandom_range(1, 4));
                else if ($urandom_range(0, 99) < 25)
                    bus.i_rx_data = 8'h00;
                else
                    bus.i_rx_data = 8'($urandom_range(0, 255));
                idle(1);
            end
        end
        reset          = 1'b0;
        bus.i_rx_valid = 1'b0;
        bus.i_alu_done = 1'b0;
        idle(2 * T + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_cmd_loader.md
# alu_cmd_loader

Byte-stream command framer sitting directly upstream of the ALU. Collects an opcode byte and two BITNESS-wide operands from the UART receive path, validates the opcode, and presents a registered operand set with a one-cycle start strobe to the ALU. Holds off further commands until the ALU signals completion, and reports framing faults through an error strobe and code.

## Interface
- BITNESS, 8: operand width in bits; must be a multiple of 8 (8, 16, 24, 32 supported).
- TIMEOUT_CYCLES, 1000: max idle cycles between bytes of one frame, and max cycles waiting for ALU completion; ≥ 2.
- i_clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- i_rx_data  in  8  received byte, valid only when i_rx_valid is high.
- i_rx_valid  in  1  one-cycle strobe per received byte; no backpressure.
- i_alu_done  in  1  ALU completion strobe (ALU o_ready).
- o_op_code  out  8  registered opcode to ALU.
- o_num_1  out  BITNESS  registered first operand.
- o_num_2  out  BITNESS  registered second operand.
- o_alu_ready  out  1  one-cycle start strobe to ALU (ALU i_ready).
- o_busy  out  1  high in every state except IDLE.
- o_error  out  1  one-cycle fault strobe.
- o_err_code  out  3  fault code, valid with o_error, holds last value otherwise.

## Operation
- Frame: 1 opcode byte, then BYTES = BITNESS/8 bytes of num_1 MSB first, then BYTES bytes of num_2 MSB first.
- Valid opcodes: 0x01 ADD, 0x02 SUB, 0x03 MUL, 0x04 DIV. Anything else: o_error, o_err_code=1 (BAD_OP), byte discarded, stay IDLE.
- States: IDLE → NUM1 (valid opcode) → NUM2 (after BYTES bytes) → DISPATCH (after BYTES bytes) → WAIT_ALU → IDLE (i_alu_done).
- Byte counter 0..BYTES-1, cleared on each state entry; operands shift left 8 and insert new byte.
- Operand shift registers are internal; o_num_1/o_num_2/o_op_code update only on entry to DISPATCH and hold until the next dispatch.
- Inter-byte timeout in NUM1/NUM2: counter clears on each accepted byte; reaching TIMEOUT_CYCLES without a byte → IDLE, o_error, code 2 (TIMEOUT), partial frame discarded. Byte arriving on the expiry cycle wins: accepted, counter cleared.
- WAIT_ALU timeout: TIMEOUT_CYCLES without i_alu_done → IDLE, o_error, code 2.
- Byte arriving in DISPATCH or WAIT_ALU: dropped, o_error, code 3 (OVERRUN); state unaffected.
- i_alu_done outside WAIT_ALU: ignored.
- Reset mid-frame: partial frame discarded, IDLE next cycle.

## Timing
- Reset values: o_op_code=0, o_num_1=0, o_num_2=0, o_alu_ready=0, o_busy=0, o_error=0, o_err_code=0.
- Last num_2 byte at cycle M → outputs loaded and o_alu_ready high at M+1, exactly one cycle; WAIT_ALU from M+2.
- i_alu_done at cycle D in WAIT_ALU → IDLE at D+1; opcode byte accepted at D+1.
- o_error asserted the cycle after the offending byte/expiry; o_err_code updated same edge.

## Configuration
- ALU_DIV_ZERO_CHECK_EN defined: DIV frame with num_2==0 does not dispatch; at M+1 o_error, code 4 (DIV_ZERO), outputs unchanged, return to IDLE.
- Not defined: DIV by zero dispatched like any other frame; code 4 never produced.

## Structure
- Shared package: opcode constants (ADD/SUB/MUL/DIV, identical values to ALU), error codes (NONE=0, BAD_OP=1, TIMEOUT=2, OVERRUN=3, DIV_ZERO=4), state encoding.
- One sub-module: alu_cmd_timeout, loadable down-counter with clear and expiry strobe, shared by inter-byte and WAIT_ALU timeouts.

## Test plan
- BITNESS=8: bytes 0x01,0x05,0x03 → o_op_code=0x01, o_num_1=0x05, o_num_2=0x03, o_alu_ready one cycle at M+1; i_alu_done → o_busy low next cycle.
- BITNESS=16: 0x03,0x12,0x34,0x00,0x02 → o_num_1=0x1234, o_num_2=0x0002, op 0x03.
- Byte 0x07 in IDLE → o_error, code 1, o_busy stays 0, next valid frame dispatches normally.
- 0x02,0x09 then TIMEOUT_CYCLES idle → o_error code 2, IDLE; subsequent 0x02,0x09,0x04 → dispatch num_1=9, num_2=4.
- Byte during WAIT_ALU → o_error code 3, still WAIT_ALU; no second o_alu_ready.
- 0x04,0x08,0x00: with ALU_DIV_ZERO_CHECK_EN → code 4, no o_alu_ready; without → dispatch num_2=0.
